// File: rtl/iob_merge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iob_merge_pkg : FSM state type and IOb slice-width helpers for iob_merge   |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
package iob_merge_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Request slice layout, MSB first: {valid, address, wdata, wstrb}
    function automatic int req_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    // Response slice layout, MSB first: {rdata, ready}
    function automatic int resp_width(input int data_w);
        return data_w + 1;
    endfunction

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/iob_merge_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iob_merge_if : N_PORTS concatenated IOb request/response slices            |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface iob_merge_if
    import iob_merge_pkg::*;
#(
    parameter int N_PORTS = 1,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    localparam int REQ_W  = req_width(ADDR_W, DATA_W);
    localparam int RESP_W = resp_width(DATA_W);

    logic [N_PORTS*REQ_W-1:0]  req;
    logic [N_PORTS*RESP_W-1:0] resp;

    modport master (output req, input  resp);
    modport slave  (input  req, output resp);
endinterface
`default_nettype wire

// File: rtl/iob_merge_arb.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iob_merge_arb : request vector + round-robin pointer -> encoded grant      |
// | IOB_MERGE_FIXED_PRIO_EN selects fixed lowest-index priority. Revision 1.0  |
// +----------------------------------------------------------------------------+
module iob_merge_arb #(
    parameter int N_MASTERS = 2,
    parameter int SEL_W     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] req_i,
    input  logic                 done_i,
    input  logic [SEL_W-1:0]     done_sel_i,
    output logic                 grant_vld_o,
    output logic [SEL_W-1:0]     grant_idx_o
);

`ifdef IOB_MERGE_FIXED_PRIO_EN
    logic unused_rr;
    assign unused_rr = ^{clk, rst, done_i, done_sel_i};

    always_comb begin
        grant_vld_o = 1'b0;
        grant_idx_o = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                grant_vld_o = 1'b1;
                grant_idx_o = SEL_W'(i);
            end
        end
    end
`else
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] ptr_d;

    always_comb begin
        ptr_d = (int'(done_sel_i) == N_MASTERS - 1) ? '0 : done_sel_i + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (done_i) begin
            ptr_q <= ptr_d;
        end
    end

    // Scan from the farthest offset down so the one nearest the pointer wins.
    always_comb begin
        int idx;
        idx         = 0;
        grant_vld_o = 1'b0;
        grant_idx_o = '0;
        for (int k = N_MASTERS - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_MASTERS) begin
                idx = idx - N_MASTERS;
            end
            if (req_i[idx]) begin
                grant_vld_o = 1'b1;
                grant_idx_o = SEL_W'(idx);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: rtl/iob_merge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iob_merge : merges N_MASTERS IOb masters onto one slave, one txn at a time |
// | Option IOB_MERGE_FIXED_PRIO_EN (see iob_merge_arb). Revision 1.0           |
// +----------------------------------------------------------------------------+
module iob_merge
    import iob_merge_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    iob_merge_if.slave  m_bus,
    iob_merge_if.master s_bus
);
    localparam int REQ_W  = req_width(ADDR_W, DATA_W);
    localparam int RESP_W = resp_width(DATA_W);
    localparam int SEL_W  = sel_width(N_MASTERS);

    state_t               state_q;
    logic [SEL_W-1:0]     sel_q;
    logic [REQ_W-1:0]     req_arr [N_MASTERS];
    logic [N_MASTERS-1:0] valid;
    logic                 grant_vld;
    logic [SEL_W-1:0]     grant_idx;
    logic                 busy;
    logic                 done;
    logic                 s_ready;
    logic [DATA_W-1:0]    s_rdata;

    assign s_ready = s_bus.resp[0];
    assign s_rdata = s_bus.resp[RESP_W-1:1];
    assign busy    = (state_q == ST_BUSY);
    assign done    = busy && s_ready;

    generate
        for (genvar i = 0; i < N_MASTERS; i++) begin : g_port
            assign req_arr[i] = m_bus.req[i*REQ_W +: REQ_W];
            assign valid[i]   = req_arr[i][REQ_W-1];
            assign m_bus.resp[i*RESP_W +: RESP_W] =
                (busy && (sel_q == SEL_W'(i))) ? {s_rdata, s_ready} : '0;
        end
    endgenerate

    // The granted master's slice is forwarded live; IOb holds it stable.
    assign s_bus.req = busy ? req_arr[sel_q] : '0;

    iob_merge_arb #(
        .N_MASTERS (N_MASTERS),
        .SEL_W     (SEL_W)
    ) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_i       (valid),
        .done_i      (done),
        .done_sel_i  (sel_q),
        .grant_vld_o (grant_vld),
        .grant_idx_o (grant_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld) begin
                        sel_q   <= grant_idx;
                        state_q <= ST_BUSY;
                    end
                end
                // Completion wins over a same-cycle valid drop; a drop alone aborts.
                ST_BUSY: begin
                    if (s_ready || !valid[sel_q]) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
